// File: rtl/fork_avalon_st_pkg.sv
// Shared types and CSR map for the Avalon-ST fork.
package fork_avalon_st_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'b001,
        WRITE_DATA = 3'b010,
        WRITE_EOP  = 3'b100
    } fork_state_t;

    localparam logic [2:0] CSR_STATE    = 3'd0;
    localparam logic [2:0] CSR_PEND     = 3'd1;
    localparam logic [2:0] CSR_LAST_LO  = 3'd2;
    localparam logic [2:0] CSR_LAST_HI  = 3'd3;
    localparam logic [2:0] CSR_COUNT_LO = 3'd4;
    localparam logic [2:0] CSR_COUNT_HI = 3'd5;

    localparam int ABORT_BIT = 0;

endpackage

// File: rtl/fork_avalon_st_if.sv
// Avalon-ST stream bundle; master is the word source, slave the sink.
interface fork_avalon_st_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  ready;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  startofpacket;
    logic                  endofpacket;

    modport master (
        input  ready,
        output valid,
        output data,
        output startofpacket,
        output endofpacket
    );

    modport slave (
        output ready,
        input  valid,
        input  data,
        input  startofpacket,
        input  endofpacket
    );
endinterface

// File: rtl/fork_out_slot.sv
// One fork output: pending flag plus zero-gated data/eop drive.
module fork_out_slot #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  eop,
    output logic                  pend,
    output logic                  hs,
    fork_avalon_st_if.master      out_st
);

    assign hs = pend && out_st.ready;

    always_ff @(posedge clock) begin
        if (reset || abort) begin
            pend <= 1'b0;
        end else if (load) begin
            pend <= 1'b1;
        end else if (hs) begin
            pend <= 1'b0;
        end
    end

    // Idle outputs present all-zero data so downstream never sees stale words.
    assign out_st.valid         = pend;
    assign out_st.data          = pend ? word : '0;
    assign out_st.endofpacket   = pend && eop;
    assign out_st.startofpacket = 1'b0;

endmodule

// File: rtl/fork_avalon_st.sv
// Avalon-ST 1-to-2 fork with CSR status/abort; FORK_AVALON_ST_WORD_COUNT_EN adds a per-packet word counter.
module fork_avalon_st
    import fork_avalon_st_pkg::*;
#(
    parameter int                    DATA_WIDTH       = 8,
    parameter int                    CSR_WIDTH        = 8,
    parameter logic                  SEND_ENDOFPACKET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] END_PACKET_VALUE = '0,
    parameter int                    COUNT_WIDTH      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    fork_avalon_st_if.slave      in_st,
    fork_avalon_st_if.master     a_st,
    fork_avalon_st_if.master     b_st,
    input  logic [2:0]           csr_address,
    input  logic                 csr_read,
    input  logic                 csr_write,
    output logic [CSR_WIDTH-1:0] csr_readdata,
    input  logic [CSR_WIDTH-1:0] csr_writedata
);

    fork_state_t             state;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic [DATA_WIDTH-1:0]   last_data;
    logic [DATA_WIDTH-1:0]   slot_word;
    logic [COUNT_WIDTH-1:0]  word_count;
    logic                    slot_eop;
    logic                    in_hs;
    logic                    abort;
    logic                    load;
    logic                    a_pend, b_pend;
    logic                    a_hs, b_hs;
    logic                    all_clear;
    logic                    unused_sop;
    logic [CSR_WIDTH-1:0]    unused_wdata;

    assign unused_sop   = in_st.startofpacket;
    assign unused_wdata = csr_writedata;

    assign in_st.ready = (state == IDLE);
    assign in_hs       = in_st.valid && in_st.ready;
    assign abort       = csr_write && (csr_address == CSR_STATE) && csr_writedata[ABORT_BIT];
    assign load        = in_hs && !abort && (!in_st.endofpacket || SEND_ENDOFPACKET);

    // Exit when every still-pending output is handshaking this cycle.
    assign all_clear = (!a_pend || a_hs) && (!b_pend || b_hs);

    assign slot_eop  = (state == WRITE_EOP);
    assign slot_word = slot_eop ? END_PACKET_VALUE : hold_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last_data <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        if (!in_st.endofpacket) begin
                            last_data <= in_st.data;
                            state     <= WRITE_DATA;
                        end else if (SEND_ENDOFPACKET) begin
                            state <= WRITE_EOP;
                        end
                    end
                end
                WRITE_DATA: begin
                    if (all_clear) state <= IDLE;
                end
                WRITE_EOP: begin
                    if (all_clear) begin
                        state     <= IDLE;
                        last_data <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data word holding register; only meaningful while a slot is pending.
    always_ff @(posedge clock) begin
        if (in_hs && !in_st.endofpacket) hold_data <= in_st.data;
    end

`ifdef FORK_AVALON_ST_WORD_COUNT_EN
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset || abort) begin
            word_count <= '0;
        end else if (state == IDLE && in_hs) begin
            if (!in_st.endofpacket)     word_count <= sat_inc(word_count);
            else if (!SEND_ENDOFPACKET) word_count <= '0;
        end else if (state == WRITE_EOP && all_clear) begin
            word_count <= '0;
        end
    end
`else
    assign word_count = '0;
`endif

    fork_out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_a (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .abort  (abort),
        .word   (slot_word),
        .eop    (slot_eop),
        .pend   (a_pend),
        .hs     (a_hs),
        .out_st (a_st)
    );

    fork_out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_b (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .abort  (abort),
        .word   (slot_word),
        .eop    (slot_eop),
        .pend   (b_pend),
        .hs     (b_hs),
        .out_st (b_st)
    );

    always_comb begin
        csr_readdata = '0;
        if (csr_read) begin
            case (csr_address)
                CSR_STATE:    csr_readdata = CSR_WIDTH'(state);
                CSR_PEND:     csr_readdata = CSR_WIDTH'({a_pend, b_pend});
                CSR_LAST_LO:  csr_readdata = CSR_WIDTH'(last_data);
                CSR_LAST_HI:  csr_readdata = CSR_WIDTH'(last_data >> CSR_WIDTH);
                CSR_COUNT_LO: csr_readdata = CSR_WIDTH'(word_count);
                CSR_COUNT_HI: csr_readdata = CSR_WIDTH'(word_count >> CSR_WIDTH);
                default:      csr_readdata = '0;
            endcase
        end
    end

endmodule

// File: doc/fork_avalon_st.md
Name: fork_avalon_st

Overview:
- Duplicates one Avalon-ST input stream onto two independent Avalon-ST outputs (a, b). Every input word, including the end-of-packet marker, is delivered exactly once on each output.
- Each output has its own backpressure. The input advances only after both outputs have taken the current word.
- Sits upstream of the ordered-merge stages in the hamming network. It fans a single sorted stream out to parallel scaler/merge paths.
- A CSR port exposes status, debug data and a soft-abort.

Parameters:
- DATA_WIDTH, 8: width of in/a/b data.
- CSR_WIDTH, 8: width of CSR read/write data.
- SEND_ENDOFPACKET, 1'b1: 1 = forward input EOP as a marker word on both outputs; 0 = consume EOP silently.
- END_PACKET_VALUE, 0: data value driven with the EOP marker.
- COUNT_WIDTH, 16: width of the per-packet word counter (optional feature).

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- in_ready  out  1  input may transfer
- in_valid  in  1  input word present
- in_data  in  DATA_WIDTH  input word
- in_startofpacket  in  1  ignored
- in_endofpacket  in  1  input word is the EOP marker
- a_ready  in  1  output a sink ready
- a_valid  out  1  output a word present
- a_data  out  DATA_WIDTH  output a word
- a_startofpacket  out  1  tied 0
- a_endofpacket  out  1  output a EOP marker
- b_ready, b_valid, b_data, b_startofpacket, b_endofpacket: same as a, for output b
- csr_address  in  3  CSR register select
- csr_read  in  1  CSR read strobe
- csr_write  in  1  CSR write strobe
- csr_readdata  out  CSR_WIDTH  CSR read data
- csr_writedata  in  CSR_WIDTH  CSR write data

Behaviour:
- Clock and reset are decided: one clock, `clock`; reset is synchronous and active-high, port `reset`.
- Reset values:
  - state=IDLE; a_pend=b_pend=0; last_data=0; word_count=0.
  - Outputs: in_ready=1, a_valid=b_valid=0, a/b_endofpacket=0, a/b_data=0.
- FSM encoding: one-hot, IDLE=3'b001, WRITE_DATA=3'b010, WRITE_EOP=3'b100.
- Transfer rules: input transfers on in_valid&&in_ready; output x transfers on x_valid&&x_ready. Readylatency 0.
- IDLE:
  - in_ready=1.
  - On transfer with !in_endofpacket: latch in_data into hold and last_data, set a_pend=b_pend=1, word_count++, go to WRITE_DATA.
  - On transfer with in_endofpacket and SEND_ENDOFPACKET=1: set a_pend=b_pend=1, go to WRITE_EOP.
  - On transfer with in_endofpacket and SEND_ENDOFPACKET=0: word_count=0, stay in IDLE.
- WRITE_DATA:
  - in_ready=0. x_valid=x_pend; x_data=hold; x_endofpacket=0.
  - Each x_pend clears on its own handshake.
  - When both pends are clear after this cycle (including simultaneous a/b handshakes): go to IDLE.
- WRITE_EOP:
  - Same as WRITE_DATA, except x_data=END_PACKET_VALUE and x_endofpacket=x_pend.
  - Exit to IDLE also resets word_count=0 and last_data=0.
- Data stability: a/b data hold stable while valid and unacknowledged; an output never drops valid without a handshake.
- Throughput: 2 cycles per word when both sinks are ready (minimum latency 1 cycle input to output valid).
- Stall isolation: a stalled sink stalls the input, never the other output's pending word.
- Idle outputs: x_data=0 whenever x_valid=0.
- CSR write: csr_write to address 0 with csr_writedata[0]=1 is a soft abort. Next cycle: state=IDLE, pends=0, word_count=0. Takes priority over any same-cycle handshake; a word handshaked in that cycle is considered lost. Other addresses/bits: no effect.
- CSR read (combinational; csr_readdata=0 when !csr_read):
  - 0: state
  - 1: {a_pend, b_pend}
  - 2: last_data[CSR_WIDTH-1:0]
  - 3: last_data upper bits, or 0 if DATA_WIDTH<=CSR_WIDTH
  - 4: word_count low
  - 5: word_count high
  - 6, 7: 0
- Reset mid-operation: pending words are dropped and the reset values apply on the next edge.

Optional Feature:
- Macro: FORK_AVALON_ST_WORD_COUNT_EN.
- Defined: word_count register of COUNT_WIDTH is implemented. Increments per forwarded data word and saturates at all-ones. Clears on EOP, abort and reset. Readable at CSR addresses 4/5.
- Undefined: no counter is built; addresses 4/5 read 0.

Decomposition:
- Package fork_avalon_st_pkg: state enum, CSR address localparams (CSR_STATE=0 … CSR_COUNT_HI=5), abort bit index.
- Sub-module fork_out_slot, instantiated twice: holds the pend flag, drives valid/data/endofpacket, and clears on handshake or abort.

Test Plan:
- Both sinks always ready; input 3,5,7 then EOP -> a and b each see 3,5,7 then EOP marker data 0 with eop=1; words are spaced by 2 cycles.
- a_ready held 0 for 5 cycles while b ready; input 9 -> b takes 9 immediately, a_valid holds 9 for 5 cycles, in_ready stays 0 until a handshakes.
- Simultaneous a/b handshake on word 4 -> state returns to IDLE next cycle; in_ready=1.
- SEND_ENDOFPACKET=0; input 2, EOP -> outputs show only 2; no eop ever asserted; word_count reads 0 after EOP.
- Abort write (addr 0, data 1) while in WRITE_DATA holding 6 with b pending -> next cycle b_valid=0, CSR0 reads 3'b001.
- FORK_AVALON_ST_WORD_COUNT_EN defined; 300 words with COUNT_WIDTH=16, CSR_WIDTH=8 -> addr4 reads 0x2C, addr5 reads 0x01; reset mid-stream -> both read 0.
